iterative_shifter: RTL and testbench



---
 rtl/iterative_shifter.sv | 184 ++++++++++++++++++
 tb/tb_iterative_shifter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// Multicycle 32-bit shift unit: one 4-bit or 1-bit step per cycle on a working register.
// Optional logical right shift (op 10) is built only when SHIFT_SRL_EN is defined.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  localparam logic [SHAMT_W-1:0] BIG_STEP   = SHAMT_W'(3'd4);
  localparam logic [SHAMT_W-1:0] SMALL_STEP = SHAMT_W'(1'b1);
  localparam logic [SHAMT_W-1:0] REM_ZERO   = {SHAMT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   work_r;
  logic [SHAMT_W-1:0] rem_r;
  logic [1:0]         op_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  logic               accept_s;
  logic               out_fire_s;
  logic               big_step_s;
  logic [SHAMT_W-1:0] rem_nxt_s;
  logic [SHAMT_W-1:0] shamt_eff_s;
  logic [WIDTH-1:0]   step_s;
  logic               in_ready_nxt_s;
  logic               out_valid_nxt_s;
  logic               busy_nxt_s;

  // Reserved ops are folded into a zero-length shift, giving a plain passthrough.
  function automatic logic op_is_supported(input logic [1:0] op_v);
    logic ok;
    case (op_v)
      OP_SLL:  ok = 1'b1;
      OP_SRA:  ok = 1'b1;
`ifdef SHIFT_SRL_EN
      OP_SRL:  ok = 1'b1;
`else
      OP_SRL:  ok = 1'b0;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // One shift step; SRA fill uses the sign bit as it was before this step.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] w,
    input logic [1:0]       op_v,
    input logic             big
  );
    logic [WIDTH-1:0] r;
    case (op_v)
      OP_SLL: begin
        if (big) r = {w[WIDTH-5:0], 4'b0000};
        else     r = {w[WIDTH-2:0], 1'b0};
      end
      OP_SRA: begin
        if (big) r = {{4{w[WIDTH-1]}}, w[WIDTH-1:4]};
        else     r = {w[WIDTH-1], w[WIDTH-1:1]};
      end
`ifdef SHIFT_SRL_EN
      OP_SRL: begin
        if (big) r = {4'b0000, w[WIDTH-1:4]};
        else     r = {1'b0, w[WIDTH-1:1]};
      end
`endif
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept_s    = in_valid && in_ready_r;
  assign out_fire_s  = out_valid_r && out_ready;
  assign shamt_eff_s = op_is_supported(op) ? shamt : REM_ZERO;
  assign big_step_s  = (rem_r >= BIG_STEP);
  assign rem_nxt_s   = big_step_s ? (rem_r - BIG_STEP) : (rem_r - SMALL_STEP);
  assign step_s      = shift_step(work_r, op_r, big_step_s);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = (shamt_eff_s == REM_ZERO) ? ST_DONE : ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (rem_nxt_s == REM_ZERO) state_nxt_s = ST_DONE;
        else                       state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_fire_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake outputs come straight from flops.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    busy_nxt_s      = 1'b0;
    case (state_nxt_s)
      ST_IDLE: in_ready_nxt_s = 1'b1;
      ST_RUN:  busy_nxt_s     = 1'b1;
      ST_DONE: begin
        out_valid_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
      end
      default: in_ready_nxt_s = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Working datapath: load on accept, step while running, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work_r <= {WIDTH{1'b0}};
      rem_r  <= REM_ZERO;
      op_r   <= 2'b00;
    end else if (accept_s) begin
      work_r <= data_in;
      rem_r  <= shamt_eff_s;
      op_r   <= op;
    end else if (state_r == ST_RUN) begin
      work_r <= step_s;
      rem_r  <= rem_nxt_s;
      op_r   <= op_r;
    end else begin
      work_r <= work_r;
      rem_r  <= rem_r;
      op_r   <= op_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign data_out  = work_r;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed self-checking bench for iterative_shifter; expectations track SHIFT_SRL_EN.
module tb_iterative_shifter;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        busy;

  int n_checks;
  int n_fail;

  iterative_shifter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an operand at a negedge; it is taken at the following posedge.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    @(negedge clock);
    in_valid = 1'b1;
    data_in  = d;
    shamt    = s;
    op       = o;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Count samples after acceptance until out_valid, bounded.
  task automatic wait_done(input string tag, input int exp_n);
    int cnt;
    cnt = 0;
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    while (!out_valid && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    check({tag, "_steps"}, cnt, exp_n);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic xfer(input string tag, input logic [31:0] d, input logic [4:0] s,
                      input logic [1:0] o, input logic [31:0] exp_d, input int exp_n);
    issue(d, s, o);
    wait_done(tag, exp_n);
    check({tag, "_data"}, data_out, exp_d);
    handshake(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    data_in   = 32'd0;
    shamt     = 5'd0;
    op        = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    reset_n = 1'b1;

    xfer("sll5",      32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020, 2);
    xfer("sra31",     32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, 10);
    xfer("sra4",      32'h7FFF_FFF0, 5'd4,  2'b01, 32'h07FF_FFFF, 1);
    xfer("zero",      32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 0);
    xfer("rsvd11",    32'h1234_5678, 5'd7,  2'b11, 32'h1234_5678, 0);
    xfer("sll31",     32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 10);
    xfer("sra6pos",   32'h1234_5678, 5'd6,  2'b01, 32'h0048_D159, 3);
`ifdef SHIFT_SRL_EN
    xfer("srl4",      32'h8000_0000, 5'd4,  2'b10, 32'h0800_0000, 1);
    xfer("srl7",      32'hF000_0000, 5'd7,  2'b10, 32'h01E0_0000, 4);
`else
    xfer("srl_off",   32'h8000_0000, 5'd4,  2'b10, 32'h8000_0000, 0);
    xfer("srl_off7",  32'hF000_0000, 5'd7,  2'b10, 32'hF000_0000, 0);
`endif

    // Backpressure: result must hold while a competing operand is presented.
    issue(32'h0000_00A5, 5'd8, 2'b00);
    wait_done("bp", 2);
    in_valid = 1'b1;
    data_in  = 32'h5555_5555;
    shamt    = 5'd0;
    op       = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_data_hold", data_out, 32'h0000_A500);
      check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    in_valid = 1'b0;
    handshake("bp");
    check("bp_not_accepted", data_out, 32'h0000_A500);

    // Asynchronous reset in the middle of a long shift.
    issue(32'h0000_0001, 5'd31, 2'b00);
    repeat (2) @(negedge clock);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", data_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    xfer("post_rst", 32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
